edge_threshold: RTL and testbench

Binarizing stage downstream of the Sobel output FIFO in the edge-detect pipeline. It pops 8-bit gradient magnitudes in raster order and tracks row and column position. Each pixel is thresholded to 0x00/0xFF, with the one-pixel frame border forced to 0x00. Results go to a downstream FIFO, and the block reports a per-frame count of edge pixels.

---
 rtl/edge_threshold_if.sv | 22 ++
 rtl/edge_threshold.sv | 111 +++++++++++
 tb/tb_edge_threshold.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/edge_threshold_if.sv
// FIFO-side handshake bundle for the edge_threshold binarizer.
// slave is the binarizer itself; master is the surrounding FIFO pair.
interface edge_threshold_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] in_dout;
  logic                  in_empty;
  logic                  in_rd_en;
  logic [DATA_WIDTH-1:0] out_din;
  logic                  out_wr_en;
  logic                  out_full;

  modport master (
    output in_dout, in_empty, out_full,
    input  in_rd_en, out_din, out_wr_en
  );

  modport slave (
    input  in_dout, in_empty, out_full,
    output in_rd_en, out_din, out_wr_en
  );
endinterface

// File: rtl/edge_threshold.sv
// Binarizes a raster stream of gradient magnitudes, zeroes the one-pixel frame border
// and reports the number of edge pixels in each completed frame.
module edge_threshold #(
  parameter int unsigned WIDTH      = 720,
  parameter int unsigned HEIGHT     = 540,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned THRESHOLD  = 64,
  parameter int unsigned CNT_WIDTH  = $clog2(WIDTH * HEIGHT + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  edge_threshold_if.slave      bus_io,
  output logic [CNT_WIDTH-1:0] edge_count_o,
  output logic                 frame_done_o
);

  localparam int unsigned ColW = $clog2(WIDTH);
  localparam int unsigned RowW = $clog2(HEIGHT);
  localparam logic [ColW-1:0] ColLast = ColW'(WIDTH - 1);
  localparam logic [RowW-1:0] RowLast = RowW'(HEIGHT - 1);
  localparam logic [DATA_WIDTH-1:0] Thresh = DATA_WIDTH'(THRESHOLD);

  typedef enum logic {StIdle, StHold} state_e;

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   hold_data_q, hold_data_d;
  logic [ColW-1:0]         col_q, col_d;
  logic [RowW-1:0]         row_q, row_d;
  logic [CNT_WIDTH-1:0]    run_cnt_q, run_cnt_d;
  logic [CNT_WIDTH-1:0]    edge_count_q, edge_count_d;
  logic                    frame_done_q, frame_done_d;

  logic                    hold_valid;
  logic                    pop;
  logic                    push;
  logic                    is_border;
  logic                    is_last;
  logic                    pix_edge;
  logic [DATA_WIDTH-1:0]   pix;

  always_comb begin
    hold_valid = (state_q == StHold);
    push       = hold_valid && !bus_io.out_full;
    // Reset gates the pop so the upstream FIFO is never drained while held in reset.
    pop        = !rst_i && !bus_io.in_empty && (!hold_valid || !bus_io.out_full);
    is_border  = (row_q == '0) || (row_q == RowLast) || (col_q == '0) || (col_q == ColLast);
    is_last    = (row_q == RowLast) && (col_q == ColLast);
    pix_edge   = !is_border && (bus_io.in_dout >= Thresh);
    pix        = pix_edge ? '1 : '0;
  end

  always_comb begin
    state_d      = state_q;
    hold_data_d  = hold_data_q;
    col_d        = col_q;
    row_d        = row_q;
    run_cnt_d    = run_cnt_q;
    edge_count_d = edge_count_q;
    frame_done_d = 1'b0;

    unique case (state_q)
      StIdle: if (pop) state_d = StHold;
      StHold: if (push && !pop) state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (pop) begin
      hold_data_d = pix;
      if (col_q == ColLast) begin
        col_d = '0;
        row_d = (row_q == RowLast) ? '0 : row_q + RowW'(1);
      end else begin
        col_d = col_q + ColW'(1);
      end
      if (is_last) begin
        edge_count_d = run_cnt_q + CNT_WIDTH'(pix_edge);
        run_cnt_d    = '0;
        frame_done_d = 1'b1;
      end else begin
        run_cnt_d = run_cnt_q + CNT_WIDTH'(pix_edge);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      hold_data_q  <= '0;
      col_q        <= '0;
      row_q        <= '0;
      run_cnt_q    <= '0;
      edge_count_q <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_data_q  <= hold_data_d;
      col_q        <= col_d;
      row_q        <= row_d;
      run_cnt_q    <= run_cnt_d;
      edge_count_q <= edge_count_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus_io.in_rd_en  = pop;
  assign bus_io.out_wr_en = push;
  assign bus_io.out_din   = hold_data_q;
  assign edge_count_o     = edge_count_q;
  assign frame_done_o     = frame_done_q;

endmodule

// File: tb/tb_edge_threshold.sv
// Directed bench for edge_threshold: a 4x3 instance for the frame-level cases and a
// 32x16 instance streamed with random data, empty gaps and back-pressure.
module tb_edge_threshold;
  localparam int SW = 4;
  localparam int SH = 3;
  localparam int BW = 32;
  localparam int BH = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  edge_threshold_if #(.DATA_WIDTH(8)) s_if ();
  edge_threshold_if #(.DATA_WIDTH(8)) b_if ();

  logic [3:0] s_cnt;
  logic       s_fd;
  logic [9:0] b_cnt;
  logic       b_fd;

  edge_threshold #(
    .WIDTH(SW), .HEIGHT(SH), .DATA_WIDTH(8), .THRESHOLD(64), .CNT_WIDTH(4)
  ) u_small (
    .clk_i(clk), .rst_i(rst), .bus_io(s_if.slave), .edge_count_o(s_cnt), .frame_done_o(s_fd)
  );

  edge_threshold #(
    .WIDTH(BW), .HEIGHT(BH), .DATA_WIDTH(8), .THRESHOLD(64), .CNT_WIDTH(10)
  ) u_big (
    .clk_i(clk), .rst_i(rst), .bus_io(b_if.slave), .edge_count_o(b_cnt), .frame_done_o(b_fd)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  logic [7:0] s_src[$];
  logic [7:0] b_src[$];
  logic [7:0] s_out[$];
  logic [7:0] b_out[$];
  logic [7:0] b_exp[$];
  logic [7:0] t1_out[$];
  int         s_ec[$];
  int         s_fdpop[$];
  int         s_pops = 0;
  int         b_pops = 0;
  int         b_fds = 0;
  int         b_ec_last = -1;
  logic       s_full = 1'b0, b_full = 1'b0, s_gap = 1'b0, b_gap = 1'b0;
  logic       s_rd, s_wr, b_rd;
  logic [7:0] s_din;

  logic [7:0] f_thr[12];
  logic [7:0] f_ff[12];
  logic [7:0] f_zero[12];

  function automatic logic [7:0] ref_pix(input int r, input int c, input int h, input int w,
                                         input logic [7:0] v);
    if (r == 0 || r == h - 1 || c == 0 || c == w - 1) return 8'h00;
    return (v >= 8'd64) ? 8'hFF : 8'h00;
  endfunction

  task automatic drive();
    s_if.in_empty = (s_src.size() == 0) || s_gap;
    s_if.in_dout  = (s_src.size() != 0) ? s_src[0] : 8'h00;
    s_if.out_full = s_full;
    b_if.in_empty = (b_src.size() == 0) || b_gap;
    b_if.in_dout  = (b_src.size() != 0) ? b_src[0] : 8'h00;
    b_if.out_full = b_full;
  endtask

  // Sample mid-cycle, then retire pops and refresh the FIFO models just after the edge.
  task automatic step();
    @(negedge clk);
    s_rd  = s_if.in_rd_en;
    s_wr  = s_if.out_wr_en;
    s_din = s_if.out_din;
    if (s_fd) begin
      s_ec.push_back(int'(s_cnt));
      s_fdpop.push_back(s_pops);
    end
    if (s_rd) s_pops++;
    if (s_wr) s_out.push_back(s_din);
    b_rd = b_if.in_rd_en;
    if (b_fd) begin
      b_fds++;
      b_ec_last = int'(b_cnt);
    end
    if (b_rd) b_pops++;
    if (b_if.out_wr_en) b_out.push_back(b_if.out_din);
    @(posedge clk);
    #1;
    if (s_rd && s_src.size() != 0) void'(s_src.pop_front());
    if (b_rd && b_src.size() != 0) void'(b_src.pop_front());
    drive();
  endtask

  task automatic wait_out(input string tag, input int n);
    int cyc = 0;
    while (s_out.size() < n && cyc < 400) begin
      step();
      cyc++;
    end
    check_eq({tag, "_done"}, 32'(s_out.size() >= n), 32'd1);
  endtask

  task automatic run_small(input string tag, input logic [7:0] frame[12], input int exp_ec);
    s_out.delete();
    s_ec.delete();
    s_fdpop.delete();
    for (int i = 0; i < 12; i++) s_src.push_back(frame[i]);
    drive();
    wait_out(tag, 12);
    for (int i = 0; i < 12 && i < s_out.size(); i++)
      check_eq($sformatf("%s_pix%0d", tag, i), 32'(s_out[i]),
               32'(ref_pix(i / SW, i % SW, SH, SW, frame[i])));
    check_eq({tag, "_fd_pulses"}, 32'(s_ec.size()), 32'd1);
    if (s_ec.size() != 0) check_eq({tag, "_edge_count"}, 32'(s_ec[0]), 32'(exp_ec));
    check_eq({tag, "_edge_count_hold"}, 32'(s_cnt), 32'(exp_ec));
  endtask

  initial begin
    int cyc;
    int base;
    int exp_cnt;
    logic [7:0] held;

    for (int i = 0; i < 12; i++) begin
      f_thr[i]  = 8'hFF;
      f_ff[i]   = 8'hFF;
      f_zero[i] = 8'h00;
    end
    f_thr[5] = 8'd63;
    f_thr[6] = 8'd64;

    rst = 1'b1;
    drive();
    s_if.in_empty = 1'b0;
    s_if.in_dout  = 8'hFF;
    @(posedge clk);
    #1;
    check_eq("rst_rd_en", 32'(s_if.in_rd_en), 32'd0);
    check_eq("rst_wr_en", 32'(s_if.out_wr_en), 32'd0);
    check_eq("rst_out_din", 32'(s_if.out_din), 32'd0);
    check_eq("rst_edge_count", 32'(s_cnt), 32'd0);
    check_eq("rst_frame_done", 32'(s_fd), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive();
    step();

    // Threshold boundary: 63 -> 0x00, 64 -> 0xFF.
    run_small("thr", f_thr, 1);
    t1_out = s_out;

    run_small("border", f_ff, 2);

    // Back-pressure mid-frame; after seven pops the held pixel is (1,2) = 0xFF.
    s_out.delete();
    s_ec.delete();
    for (int i = 0; i < 12; i++) s_src.push_back(f_thr[i]);
    drive();
    for (int i = 0; i < 7; i++) step();
    s_full = 1'b1;
    drive();
    held = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq($sformatf("bp_rd_en%0d", i), 32'(s_rd), 32'd0);
      check_eq($sformatf("bp_wr_en%0d", i), 32'(s_wr), 32'd0);
      check_eq($sformatf("bp_din%0d", i), 32'(s_din), 32'(held));
    end
    s_full = 1'b0;
    drive();
    wait_out("bp", 12);
    for (int i = 0; i < 12 && i < s_out.size() && i < t1_out.size(); i++)
      check_eq($sformatf("bp_seq%0d", i), 32'(s_out[i]), 32'(t1_out[i]));
    check_eq("bp_count", 32'(s_out.size()), 32'd12);
    if (s_ec.size() != 0) check_eq("bp_edge_count", 32'(s_ec[0]), 32'd1);
    else check_eq("bp_fd_seen", 32'd0, 32'd1);

    // Reset after five pops of a fresh frame; edge_count was 1 before.
    s_out.delete();
    s_ec.delete();
    base = s_pops;
    for (int i = 0; i < 12; i++) s_src.push_back(f_ff[i]);
    drive();
    cyc = 0;
    while (s_pops - base < 5 && cyc < 100) begin
      step();
      cyc++;
    end
    check_eq("mr_pops", 32'(s_pops - base), 32'd5);
    rst = 1'b1;
    #1;
    check_eq("mr_wr_en", 32'(s_if.out_wr_en), 32'd0);
    check_eq("mr_out_din", 32'(s_if.out_din), 32'd0);
    check_eq("mr_edge_count", 32'(s_cnt), 32'd0);
    check_eq("mr_frame_done", 32'(s_fd), 32'd0);
    check_eq("mr_rd_en", 32'(s_if.in_rd_en), 32'd0);
    s_src.delete();
    drive();
    step();
    step();
    rst = 1'b0;
    drive();
    run_small("mr_fresh", f_ff, 2);

    // Two back-to-back frames.
    s_out.delete();
    s_ec.delete();
    s_fdpop.delete();
    for (int i = 0; i < 12; i++) s_src.push_back(f_ff[i]);
    for (int i = 0; i < 12; i++) s_src.push_back(f_zero[i]);
    drive();
    wait_out("wrap", 24);
    for (int i = 0; i < 24 && i < s_out.size(); i++)
      check_eq($sformatf("wrap_pix%0d", i), 32'(s_out[i]),
               32'(ref_pix((i % 12) / SW, i % SW, SH, SW, (i < 12) ? 8'hFF : 8'h00)));
    check_eq("wrap_fd_pulses", 32'(s_ec.size()), 32'd2);
    if (s_ec.size() == 2) begin
      check_eq("wrap_ec0", 32'(s_ec[0]), 32'd2);
      check_eq("wrap_ec1", 32'(s_ec[1]), 32'd0);
      check_eq("wrap_fd_spacing", 32'(s_fdpop[1] - s_fdpop[0]), 32'd12);
    end
    check_eq("wrap_row", 32'(u_small.row_q), 32'd0);
    check_eq("wrap_col", 32'(u_small.col_q), 32'd0);

    // Larger frame with random data, empty gaps and occasional out_full.
    exp_cnt = 0;
    for (int i = 0; i < BW * BH; i++) begin
      logic [7:0] v;
      v = 8'($urandom_range(0, 255));
      b_src.push_back(v);
      b_exp.push_back(ref_pix(i / BW, i % BW, BH, BW, v));
      if (ref_pix(i / BW, i % BW, BH, BW, v) == 8'hFF) exp_cnt++;
    end
    cyc = 0;
    while (b_out.size() < BW * BH && cyc < 20000) begin
      b_gap  = ($urandom_range(0, 2) == 0);
      b_full = ($urandom_range(0, 4) == 0);
      drive();
      step();
      cyc++;
    end
    b_gap  = 1'b0;
    b_full = 1'b0;
    drive();
    check_eq("rand_count", 32'(b_out.size()), 32'(BW * BH));
    for (int i = 0; i < BW * BH && i < b_out.size(); i++)
      check_eq($sformatf("rand_pix%0d", i), 32'(b_out[i]), 32'(b_exp[i]));
    check_eq("rand_fd_pulses", 32'(b_fds), 32'd1);
    check_eq("rand_edge_count", 32'(b_ec_last), 32'(exp_cnt));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
